display_tx_scheduler: RTL and testbench

Arbitrates two byte sources, the CPU terminal-output path and an auxiliary source (serial/paste loader), into the display's single TX write port. Bytes are buffered in a small FIFO and issued one at a time under the display's ready handshake. The block also sequences a full-frame clear-screen pulse. It sits between the PIA/loader logic and the `display` block's `w_en`/`din`/`ready`/`clr_screen` pins.

---
 rtl/display_tx_scheduler.sv | 96 +++++++++
 tb/tb_display_tx_scheduler.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/display_tx_scheduler.sv
// display_tx_scheduler: arbitrates CPU/aux bytes through a FIFO into the display TX port
// and sequences the full-frame clear-screen pulse.
module display_tx_scheduler #(
  parameter int FIFO_DEPTH = 8,
  parameter int CLR_PIXELS = 119928
) (
  input  logic                        sys_clock,
  input  logic                        reset_n,
  input  logic                        pixel_clken,
  input  logic                        cpu_req,
  input  logic [7:0]                  cpu_data,
  output logic                        cpu_ack,
  input  logic                        aux_req,
  input  logic [7:0]                  aux_data,
  output logic                        aux_ack,
  input  logic                        clr_req,
  input  logic                        disp_ready,
  output logic                        disp_w_en,
  output logic [7:0]                  disp_din,
  output logic                        disp_clr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLR_PIXELS);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(CLR_PIXELS - 1);
  typedef enum logic [1:0] {IDLE, SEND, CLEAR} state_t;
  state_t        state_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] pix_q;
  logic          rr_q, allowed, aux_win, push, pop;
  logic [7:0]    push_data;
  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign allowed    = count_q < FULL && state_q != CLEAR;
  assign aux_win    = aux_req & (~cpu_req | rr_q);
  assign cpu_ack    = cpu_req & ~aux_win & allowed;
  assign aux_ack    = aux_win & allowed;
  assign push       = cpu_ack | aux_ack;
  assign push_data  = aux_ack ? aux_data : cpu_data;
  assign pop        = state_q == IDLE && count_q != '0 && disp_ready;
  assign count_d    = count_q + {AW'(0), push} - {AW'(0), pop};
  assign fifo_level = count_q;
  assign busy       = count_q != '0 || state_q != IDLE;
  always_ff @(posedge sys_clock)
    if (push) mem_q[wr_q] <= push_data;
  always_ff @(posedge sys_clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      pix_q     <= '0;
      rr_q      <= 1'b0;
      disp_w_en <= 1'b0;
      disp_din  <= '0;
      disp_clr  <= 1'b0;
    end else begin
      rr_q <= cpu_ack ? 1'b1 : aux_ack ? 1'b0 : rr_q;
      if (clr_req) begin
        state_q   <= CLEAR;
        disp_clr  <= 1'b1;
        disp_w_en <= 1'b0;
        count_q   <= '0;
        wr_q      <= '0;
        rd_q      <= '0;
        pix_q     <= '0;
      end else begin
        count_q <= count_d;
        if (push) wr_q <= wr_q + AW'(1);
        if (pop) rd_q <= rd_q + AW'(1);
        case (state_q)
          IDLE: if (pop) begin
            disp_din  <= mem_q[rd_q];
            disp_w_en <= 1'b1;
            state_q   <= SEND;
          end
          SEND: if (!disp_ready) begin
            disp_w_en <= 1'b0;
            state_q   <= IDLE;
          end
          CLEAR: if (pixel_clken) begin
            pix_q <= pix_q == LAST ? '0 : pix_q + CW'(1);
            if (pix_q == LAST) begin
              disp_clr <= 1'b0;
              state_q  <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_display_tx_scheduler.sv
// tb_display_tx_scheduler: directed stimulus with a queue-based reference model checked every cycle.
module tb_display_tx_scheduler;
  localparam int DEPTH = 8;
  localparam int CP = 40;
  logic sys_clock = 0, reset_n = 0, pixel_clken = 0, cpu_req = 0, aux_req = 0, clr_req = 0, disp_ready = 0;
  logic [7:0] cpu_data = 0, aux_data = 0;
  logic cpu_ack, aux_ack, disp_w_en, disp_clr, busy;
  logic [7:0] disp_din;
  logic [3:0] fifo_level;
  int checks = 0, failures = 0;
  display_tx_scheduler #(.FIFO_DEPTH(DEPTH), .CLR_PIXELS(CP)) dut (
    .sys_clock(sys_clock), .reset_n(reset_n), .pixel_clken(pixel_clken),
    .cpu_req(cpu_req), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
    .aux_req(aux_req), .aux_data(aux_data), .aux_ack(aux_ack),
    .clr_req(clr_req), .disp_ready(disp_ready), .disp_w_en(disp_w_en),
    .disp_din(disp_din), .disp_clr(disp_clr), .fifo_level(fifo_level), .busy(busy)
  );
  always #5 sys_clock = ~sys_clock;
  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask
  // Reference model: a byte queue plus the display-side mode, advanced once per cycle.
  localparam int M_IDLE = 0, M_SEND = 1, M_CLEAR = 2;
  byte unsigned q[$], got[$];
  int mode = M_IDLE, pix = 0;
  bit mvalid = 0, m_wen = 0, m_clr = 0, rr_aux = 0, prev_wen = 0, e_cpu, e_aux, ok, popping;
  byte unsigned m_din = 0;
  always begin
    @(negedge sys_clock);
    #2;
    ok = q.size() < DEPTH && mode != M_CLEAR;
    e_cpu = ok && cpu_req && (!aux_req || !rr_aux);
    e_aux = ok && aux_req && (!cpu_req || rr_aux);
    if (mvalid) begin
      chk("cpu_ack", cpu_ack, e_cpu);
      chk("aux_ack", aux_ack, e_aux);
      chk("disp_w_en", disp_w_en, m_wen);
      chk("disp_clr", disp_clr, m_clr);
      chk("fifo_level", fifo_level, q.size());
      chk("busy", busy, q.size() > 0 || mode != M_IDLE);
      if (m_wen) chk("disp_din", disp_din, m_din);
      if (disp_w_en && !prev_wen) got.push_back(disp_din);
    end
    prev_wen = disp_w_en;
    if (!reset_n) begin
      q.delete(); mode = M_IDLE; m_wen = 0; m_din = 0; m_clr = 0; pix = 0; rr_aux = 0; mvalid = 1;
    end else if (mvalid) begin
      if (e_cpu) rr_aux = 1; else if (e_aux) rr_aux = 0;
      if (clr_req) begin
        q.delete(); mode = M_CLEAR; m_clr = 1; m_wen = 0; pix = 0;
      end else begin
        popping = mode == M_IDLE && q.size() > 0 && disp_ready;
        if (e_cpu) q.push_back(cpu_data);
        if (e_aux) q.push_back(aux_data);
        if (mode == M_CLEAR) begin
          if (pixel_clken) begin
            pix++;
            if (pix == CP) begin mode = M_IDLE; m_clr = 0; pix = 0; end
          end
        end else if (mode == M_SEND) begin
          if (!disp_ready) begin mode = M_IDLE; m_wen = 0; end
        end else if (popping) begin
          m_din = q.pop_front(); m_wen = 1; mode = M_SEND;
        end
      end
    end
  end
  task automatic step();
    @(negedge sys_clock);
  endtask
  byte unsigned ord[$];
  byte unsigned exp_ord[8] = '{8'h41, 8'h61, 8'h42, 8'h62, 8'h43, 8'h63, 8'h44, 8'h64};
  int nc, na, pulses, acks, idx;
  initial begin
    step(); step();
    step(); reset_n = 1;
    #1 chk("rst_w_en", disp_w_en, 0); chk("rst_clr", disp_clr, 0);
    chk("rst_level", fifo_level, 0); chk("rst_busy", busy, 0);
    // single byte
    disp_ready = 1;
    step(); cpu_req = 1; cpu_data = 8'hC1;
    #1 chk("single_ack", cpu_ack, 1);
    step(); cpu_req = 0;
    step(); #1 chk("single_w_en", disp_w_en, 1); chk("single_din", disp_din, 8'hC1);
    disp_ready = 0;
    step(); #1 chk("single_release", disp_w_en, 0); chk("single_level", fifo_level, 0);
    // round-robin from a fresh pointer
    step(); reset_n = 0;
    step(); reset_n = 1;
    nc = 0; na = 0;
    for (int c = 0; c < 20 && (nc < 4 || na < 4); c++) begin
      step();
      cpu_req = nc < 4; aux_req = na < 4;
      cpu_data = 8'(8'h41 + nc); aux_data = 8'(8'h61 + na);
      #1;
      if (cpu_ack) begin ord.push_back(cpu_data); nc++; end
      if (aux_ack) begin ord.push_back(aux_data); na++; end
    end
    step(); cpu_req = 0; aux_req = 0;
    #1 chk("rr_level", fifo_level, 8); chk("rr_count", ord.size(), 8);
    for (int i = 0; i < 8 && i < ord.size(); i++) chk("rr_order", ord[i], exp_ord[i]);
    // full: pop cycle does not free a slot
    step(); cpu_req = 1; cpu_data = 8'h45; disp_ready = 1;
    #1 chk("full_pop_ack", cpu_ack, 0);
    step(); #1 chk("full_resume_ack", cpu_ack, 1); chk("full_level", fifo_level, 7);
    chk("full_din", disp_din, 8'h41);
    step(); cpu_req = 0; disp_ready = 0;
    // clear during SEND with 5 queued
    repeat (2) begin step(); disp_ready = 1; step(); disp_ready = 0; end
    step(); disp_ready = 1;
    step(); #1 chk("pre_clr_w_en", disp_w_en, 1); chk("pre_clr_level", fifo_level, 5);
    clr_req = 1;
    step(); clr_req = 0; disp_ready = 0; cpu_req = 1; cpu_data = 8'h99;
    #1 chk("clr_w_en", disp_w_en, 0); chk("clr_on", disp_clr, 1);
    chk("clr_level", fifo_level, 0); chk("clr_busy", busy, 1);
    pulses = 0; acks = 0;
    for (int c = 0; c < 300; c++) begin
      step(); pixel_clken = c % 2 == 0;
      #1;
      if (!disp_clr) break;
      if (pixel_clken) pulses++;
      if (cpu_ack || aux_ack) acks++;
    end
    chk("clr_pulses", pulses, CP); chk("clr_acks", acks, 0); chk("clr_done", disp_clr, 0);
    step(); cpu_req = 0; pixel_clken = 0;
    // clear restart, then reset mid-clear overriding clr_req
    step(); clr_req = 1;
    step(); clr_req = 0; pixel_clken = 1;
    repeat (5) step();
    clr_req = 1;
    step(); clr_req = 0;
    repeat (CP - 5) step();
    #1 chk("restart_clr", disp_clr, 1);
    step(); reset_n = 0; clr_req = 1;
    step(); reset_n = 1; clr_req = 0; pixel_clken = 0;
    #1 chk("rst_mid_clr", disp_clr, 0); chk("rst_mid_busy", busy, 0); chk("rst_mid_level", fifo_level, 0);
    step(); aux_req = 1; aux_data = 8'h77;
    #1 chk("post_rst_ack", aux_ack, 1);
    step(); aux_req = 0; disp_ready = 1;
    step(); disp_ready = 0;
    step(); #1 chk("post_rst_byte", got.size() > 0 ? int'(got[got.size()-1]) : -1, 8'h77);
    // wrap-around
    got.delete(); idx = 0;
    for (int c = 0; c < 400 && got.size() < 20; c++) begin
      step(); cpu_req = idx < 20; cpu_data = 8'(idx); disp_ready = c % 2 == 0;
      #1 if (cpu_ack) idx++;
    end
    cpu_req = 0; disp_ready = 0;
    chk("wrap_count", got.size(), 20);
    for (int i = 0; i < 20 && i < got.size(); i++) chk("wrap_byte", got[i], i);
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
